rv32i_wb_top: RTL and testbench
===============================

// Module: rv32i_wb_top
// PURPOSE
//  Write-back stage of the RV32I pipeline; consumes the registered outputs of the memory stage.
//  Selects the final result (ALU value, link address PC+4, or aligned/extended load data).
//  Writes the result into the integer register file, which this block contains.
//  Serves the decode-stage read ports with same-cycle write-through bypass and exports a
//  retired-instruction count.
// PARAMETERS
//  XLEN     32  datapath width; only 32 is supported
//  NREGS    32  architectural registers; x0 is hardwired to zero
// PORTS
//  clk            in   1   system clock, rising-edge
//  reset          in   1   asynchronous, active-low; clears all state
//  valid_in       in   1   stage holds a real instruction (0 = bubble)
//  wb_en_in       in   1   instruction writes rd (from memory stage)
//  pc_in          in   32  PC of instruction in WB
//  iw_in          in   32  instruction word in WB
//  alu_in         in   32  ALU result / effective address
//  wb_reg_in      in   5   destination register rd
//  mem_rdata_in   in   32  raw word read from data memory at {alu_in[31:2],2'b00}
//  rs1_addr_in    in   5   decode-stage read address 1
//  rs2_addr_in    in   5   decode-stage read address 2
//  rs1_data_out   out  32  read data 1 (combinational)
//  rs2_data_out   out  32  read data 2 (combinational)
//  df_wb_en_out   out  1   forwarding: a register write occurs this cycle
//  df_wb_reg_out  out  5   forwarding: destination register
//  df_wb_data_out out  32  forwarding: value being written
//  instret_out    out  64  retired-instruction counter
// BEHAVIOUR
//  - wr_fire = valid_in & wb_en_in & (wb_reg_in != 0); wr_fire is the sole write condition.
//  - Result select (combinational, on iw_in[6:0]):
//    - LOAD 0000011: byte lane is alu_in[1:0].
//      - LB/LBU (funct3 000/100): byte selected, then sign/zero extended.
//      - LH/LHU (001/101): halfword at alu_in[1]; alu_in[0] ignored; sign/zero extended.
//      - LW (010): full word; alu_in[1:0] ignored.
//      - Any other funct3: result 32'h0.
//    - JAL 1101111 / JALR 1100111: pc_in + 4, wrapping modulo 2^32.
//    - Otherwise: alu_in.
//  - Register file write:
//    - On rising clk with wr_fire, regs[wb_reg_in] <= result.
//    - Write latency 1 cycle; the value is visible in the array from the next cycle.
//  - Read ports:
//    - rsN_data_out = 0 if rsN_addr_in == 0.
//    - Else the current result if wr_fire && wb_reg_in == rsN_addr_in (write-through).
//    - Else regs[rsN_addr_in].
//  - Forwarding outputs (combinational):
//    - df_wb_en_out = wr_fire.
//    - df_wb_reg_out = wb_reg_in.
//    - df_wb_data_out = result; it is driven even when df_wb_en_out = 0.
//  - Write attempts to x0 are dropped; x0 always reads 0.
//  - Reset (reset == 0, asynchronous):
//    - regs[1..31] <= 0 and instret <= 0 immediately.
//    - Reads return 0 while reset is held.
//    - A write in flight when reset asserts is lost.
//    - Both operations resume on the first clk edge after release.
//  - Both read ports may address the same register, or the register being written, with no
//    restriction.
// CONFIGURATION
//  RV32I_WB_INSTRET_EN defined:
//    - 64-bit counter increments by 1 on every rising clk with valid_in == 1, whether or not
//      the instruction writes a register.
//    - Wraps from 2^64-1 to 0.
//    - instret_out is the registered counter value.
//  RV32I_WB_INSTRET_EN undefined: no counter flops; instret_out tied to 64'h0.
// TESTING
//  1 Reset: assert reset=0 mid-run after writing x5=32'h1234 -> rs1 addr 5 reads 0;
//    instret_out=0.
//  2 ALU write: valid=1, wb_en=1, rd=3, iw=ADD, alu_in=32'hDEAD_BEEF.
//    -> same cycle: rs2 addr 3 = DEADBEEF (bypass), df_wb_en=1.
//    -> next cycle: reads DEADBEEF from the array.
//  3 Loads: mem_rdata=32'h8070_F0A5, rd=7.
//    - LB, alu[1:0]=0 -> x7 = FFFFFFA5.
//    - LBU, alu[1:0]=3 -> x7 = 00000080.
//    - LH, alu[1:0]=2 -> x7 = FFFF8070.
//    - LW, alu[1:0]=1 -> x7 = 8070F0A5.
//  4 Link: JAL, pc_in=32'hFFFF_FFFC, rd=1 -> x1 = 0; second case pc_in=32'h100 -> x1 = 32'h104.
//  5 x0 and bubbles:
//    - rd=0, wb_en=1, alu=5 -> x0 reads 0, df_wb_en=0.
//    - valid=0, wb_en=1, rd=4 -> x4 unchanged.
//  6 Counter (with RV32I_WB_INSTRET_EN): 10 cycles valid=1 interleaved with 3 bubbles
//    -> instret_out=10; without the macro -> 0.

Source files
------------

// File: rtl/rv32i_wb_top.sv
// RV32I write-back stage: result select, integer register file with write-through reads,
// forwarding outputs and an optional retired-instruction counter (RV32I_WB_INSTRET_EN).
module rv32i_wb_top #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            wb_en_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] iw_in,
  input  logic [XLEN-1:0] alu_in,
  input  logic [4:0]      wb_reg_in,
  input  logic [XLEN-1:0] mem_rdata_in,
  input  logic [4:0]      rs1_addr_in,
  input  logic [4:0]      rs2_addr_in,
  output logic [XLEN-1:0] rs1_data_out,
  output logic [XLEN-1:0] rs2_data_out,
  output logic            df_wb_en_out,
  output logic [4:0]      df_wb_reg_out,
  output logic [XLEN-1:0] df_wb_data_out,
  output logic [63:0]     instret_out
);

  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] result;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic            wr_fire;
  logic            unused_iw;

  assign unused_iw = ^{iw_in[31:15], iw_in[11:7]};
  assign wr_fire   = valid_in & wb_en_in & (wb_reg_in != 5'd0);

  always_comb begin
    ld_byte = mem_rdata_in[{alu_in[1:0], 3'b000} +: 8];
    ld_half = alu_in[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
    result  = alu_in;
    case (iw_in[6:0])
      OPC_LOAD: begin
        case (iw_in[14:12])
          3'b000:  result = {{24{ld_byte[7]}}, ld_byte};
          3'b100:  result = {24'h0, ld_byte};
          3'b001:  result = {{16{ld_half[15]}}, ld_half};
          3'b101:  result = {16'h0, ld_half};
          3'b010:  result = mem_rdata_in;
          default: result = '0;
        endcase
      end
      OPC_JAL, OPC_JALR: result = pc_in + 32'd4;
      default:           result = alu_in;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_fire) begin
      regs[wb_reg_in] <= result;
    end
  end

  // Reads are forced to zero while reset is held so a bypassed in-flight write cannot leak out.
  always_comb begin
    rs1_data_out = '0;
    rs2_data_out = '0;
    if (reset && rs1_addr_in != 5'd0)
      rs1_data_out = (wr_fire && wb_reg_in == rs1_addr_in) ? result : regs[rs1_addr_in];
    if (reset && rs2_addr_in != 5'd0)
      rs2_data_out = (wr_fire && wb_reg_in == rs2_addr_in) ? result : regs[rs2_addr_in];
  end

  assign df_wb_en_out   = wr_fire;
  assign df_wb_reg_out  = wb_reg_in;
  assign df_wb_data_out = result;

`ifdef RV32I_WB_INSTRET_EN
  logic [63:0] instret;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        instret <= '0;
    else if (valid_in) instret <= instret + 64'd1;
  end

  assign instret_out = instret;
`else
  assign instret_out = '0;
`endif

endmodule

// File: tb/tb_rv32i_wb_top.sv
// Randomized self-checking bench for rv32i_wb_top against a behavioural write-back model.
`timescale 1ns/1ps
module tb_rv32i_wb_top;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0, wb_en_in = 1'b0;
  logic [31:0] pc_in = '0, iw_in = '0, alu_in = '0, mem_rdata_in = '0;
  logic [4:0]  wb_reg_in = '0, rs1_addr_in = '0, rs2_addr_in = '0;
  logic [31:0] rs1_data_out, rs2_data_out, df_wb_data_out;
  logic        df_wb_en_out;
  logic [4:0]  df_wb_reg_out;
  logic [63:0] instret_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] mregs [32];
  logic [63:0] minstret = '0;

  always #5 clk = ~clk;

  rv32i_wb_top #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .wb_en_in(wb_en_in),
    .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in), .wb_reg_in(wb_reg_in),
    .mem_rdata_in(mem_rdata_in), .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .df_wb_en_out(df_wb_en_out), .df_wb_reg_out(df_wb_reg_out),
    .df_wb_data_out(df_wb_data_out), .instret_out(instret_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_iw(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] w;
    w = $urandom;
    w[6:0] = opc;
    w[14:12] = f3;
    return w;
  endfunction

  // Load data is the memory word shifted down to the addressed lane, then extended.
  function automatic logic [31:0] model_result(input logic [31:0] iw, pc, alu, mem);
    logic [31:0] w;
    if (iw[6:0] == OP_LOAD) begin
      case (iw[14:12])
        3'b000: begin w = mem >> (8 * alu[1:0]); return {{24{w[7]}}, w[7:0]}; end
        3'b100: begin w = mem >> (8 * alu[1:0]); return {24'h0, w[7:0]}; end
        3'b001: begin w = mem >> (alu[1] ? 16 : 0); return {{16{w[15]}}, w[15:0]}; end
        3'b101: begin w = mem >> (alu[1] ? 16 : 0); return {16'h0, w[15:0]}; end
        3'b010: return mem;
        default: return 32'h0;
      endcase
    end
    if (iw[6:0] == OP_JAL || iw[6:0] == OP_JALR) return pc + 32'd4;
    return alu;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic fire,
                                           input logic [4:0] rd, input logic [31:0] res);
    if (a == 5'd0) return 32'h0;
    if (fire && rd == a) return res;
    return mregs[a];
  endfunction

  function automatic logic [63:0] exp_instret();
`ifdef RV32I_WB_INSTRET_EN
    return minstret;
`else
    return 64'h0;
`endif
  endfunction

  task automatic step(input logic v, input logic en, input logic [4:0] rd,
                      input logic [31:0] iw, input logic [31:0] pc, input logic [31:0] alu,
                      input logic [31:0] mem, input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] res;
    logic fire;
    @(negedge clk);
    valid_in = v; wb_en_in = en; wb_reg_in = rd; iw_in = iw; pc_in = pc;
    alu_in = alu; mem_rdata_in = mem; rs1_addr_in = r1; rs2_addr_in = r2;
    #1;
    res  = model_result(iw, pc, alu, mem);
    fire = v && en && (rd != 5'd0);
    chk("rs1_data", {32'h0, rs1_data_out}, {32'h0, exp_read(r1, fire, rd, res)});
    chk("rs2_data", {32'h0, rs2_data_out}, {32'h0, exp_read(r2, fire, rd, res)});
    chk("df_wb_en", {63'h0, df_wb_en_out}, {63'h0, fire});
    chk("df_wb_reg", {59'h0, df_wb_reg_out}, {59'h0, rd});
    chk("df_wb_data", {32'h0, df_wb_data_out}, {32'h0, res});
    chk("instret", instret_out, exp_instret());
    @(posedge clk);
    if (reset) begin
      if (fire) mregs[rd] = res;
      if (v) minstret = minstret + 64'd1;
    end
    #1;
  endtask

  task automatic bubble_read(input logic [4:0] r1);
    step(1'b0, 1'b0, 5'd0, mk_iw(OP_ALU, 3'b000), 32'h0, 32'h0, 32'h0, r1, 5'd0);
  endtask

  initial begin
    logic [6:0]  opc;
    logic [4:0]  rd, r1, r2;
    for (int i = 0; i < 32; i++) mregs[i] = '0;

    // Reset held: in-flight write must not be visible on the read ports.
    #3;
    valid_in = 1'b1; wb_en_in = 1'b1; wb_reg_in = 5'd5; alu_in = 32'h55;
    iw_in = mk_iw(OP_ALU, 3'b000); rs1_addr_in = 5'd5; rs2_addr_in = 5'd9;
    #1;
    chk("reset_rs1", {32'h0, rs1_data_out}, 64'h0);
    chk("reset_rs2", {32'h0, rs2_data_out}, 64'h0);
    chk("reset_instret", instret_out, 64'h0);
    valid_in = 1'b0; wb_en_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // ALU write with same-cycle bypass, then from the array.
    step(1'b1, 1'b1, 5'd3, mk_iw(OP_ALU, 3'b000), 32'h40, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd3);
    chk("alu_x3", {32'h0, rs2_data_out}, 64'hDEAD_BEEF);
    step(1'b0, 1'b0, 5'd0, mk_iw(OP_ALU, 3'b000), 32'h0, 32'h0, 32'h0, 5'd3, 5'd3);
    chk("alu_x3_array", {32'h0, rs1_data_out}, 64'hDEAD_BEEF);

    // Load lanes and extension.
    step(1'b1, 1'b1, 5'd7, mk_iw(OP_LOAD, 3'b000), 32'h0, 32'h1000, 32'h8070_F0A5, 5'd7, 5'd0);
    chk("lb", {32'h0, rs1_data_out}, 64'hFFFF_FFA5);
    step(1'b1, 1'b1, 5'd7, mk_iw(OP_LOAD, 3'b100), 32'h0, 32'h1003, 32'h8070_F0A5, 5'd7, 5'd0);
    chk("lbu", {32'h0, rs1_data_out}, 64'h0000_0080);
    step(1'b1, 1'b1, 5'd7, mk_iw(OP_LOAD, 3'b001), 32'h0, 32'h1002, 32'h8070_F0A5, 5'd7, 5'd0);
    chk("lh", {32'h0, rs1_data_out}, 64'hFFFF_8070);
    step(1'b1, 1'b1, 5'd7, mk_iw(OP_LOAD, 3'b010), 32'h0, 32'h1001, 32'h8070_F0A5, 5'd7, 5'd0);
    chk("lw", {32'h0, rs1_data_out}, 64'h8070_F0A5);

    // Link address wraps.
    step(1'b1, 1'b1, 5'd1, mk_iw(OP_JAL, 3'b000), 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd1, 5'd0);
    chk("jal_wrap", {32'h0, rs1_data_out}, 64'h0);
    step(1'b1, 1'b1, 5'd1, mk_iw(OP_JAL, 3'b000), 32'h100, 32'h0, 32'h0, 5'd1, 5'd0);
    chk("jal", {32'h0, rs1_data_out}, 64'h104);

    // x0 writes dropped; bubbles do not write.
    step(1'b1, 1'b1, 5'd0, mk_iw(OP_ALU, 3'b000), 32'h0, 32'h5, 32'h0, 5'd0, 5'd0);
    chk("x0_read", {32'h0, rs1_data_out}, 64'h0);
    chk("x0_df_en", {63'h0, df_wb_en_out}, 64'h0);
    step(1'b1, 1'b1, 5'd4, mk_iw(OP_ALU, 3'b000), 32'h0, 32'hA5A5_0004, 32'h0, 5'd4, 5'd0);
    step(1'b0, 1'b1, 5'd4, mk_iw(OP_ALU, 3'b000), 32'h0, 32'h1111_2222, 32'h0, 5'd4, 5'd0);
    bubble_read(5'd4);
    chk("bubble_x4", {32'h0, rs1_data_out}, 64'hA5A5_0004);

    // Mid-run asynchronous reset with a write in flight.
    step(1'b1, 1'b1, 5'd5, mk_iw(OP_ALU, 3'b000), 32'h0, 32'h1234, 32'h0, 5'd5, 5'd0);
    chk("x5_before_reset", {32'h0, rs1_data_out}, 64'h1234);
    #2;
    valid_in = 1'b1; wb_en_in = 1'b1; wb_reg_in = 5'd6; alu_in = 32'h6666;
    rs1_addr_in = 5'd5; rs2_addr_in = 5'd6;
    reset = 1'b0;
    #1;
    chk("midreset_x5", {32'h0, rs1_data_out}, 64'h0);
    chk("midreset_instret", instret_out, 64'h0);
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    minstret = '0;
    valid_in = 1'b0; wb_en_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bubble_read(5'd6);
    chk("lost_write_x6", {32'h0, rs1_data_out}, 64'h0);
    bubble_read(5'd5);
    chk("cleared_x5", {32'h0, rs1_data_out}, 64'h0);

    // Counter: 10 valid cycles interleaved with 3 bubbles since reset.
    for (int i = 0; i < 13; i++)
      step((i % 4) != 3, 1'b0, 5'd2, mk_iw(OP_ALU, 3'b000), 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
`ifdef RV32I_WB_INSTRET_EN
    chk("instret_10", instret_out, 64'd10);
`else
    chk("instret_off", instret_out, 64'd0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    opc = OP_LOAD;
        2:       opc = ($urandom_range(0, 1) != 0) ? OP_JAL : OP_JALR;
        3:       opc = OP_ALU;
        default: opc = 7'($urandom);
      endcase
      rd = 5'($urandom);
      r1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      r2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rd,
           mk_iw(opc, 3'($urandom)), $urandom, $urandom, $urandom, r1, r2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
